// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write handshake, per-port read request/response
// lanes and the bulk-clear control. The master side drives requests and the
// slave side (the register file) returns ready, read data and busy.
interface reg_file_mp_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic                   wr_valid;
    logic                   wr_ready;
    logic [AW-1:0]          wr_sel;
    logic [WIDTH-1:0]       wr_data;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_sel;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_valid;
    logic                   clr_req;
    logic                   busy;

    modport master (
        output wr_valid, wr_sel, wr_data, rd_en, rd_sel, clr_req,
        input  wr_ready, rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, rd_en, rd_sel, clr_req,
        output wr_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: NREGS x WIDTH register file with one handshaked write port,
// NREAD registered read ports (write-first bypass) and a one-entry-per-cycle
// bulk-clear sweep that blocks writes while it runs.
// Optional feature macro: REG_FILE_MP_ZERO_REG_EN -- when defined, entry 0 is
// hardwired to zero (writes to it are accepted but dropped and never bypassed).
module reg_file_mp #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int NREAD = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    reg_file_mp_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

`ifdef REG_FILE_MP_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state;
    logic [AW-1:0]          ptr;
    logic                   busy_q;
    logic                   wr_ready_q;
    logic [WIDTH-1:0]       mem [NREGS];
    logic                   wr_fire;
    logic                   wr_keep;
    logic                   clr_active;
    logic [WIDTH-1:0]       rd_next [NREAD];
    logic [NREAD*WIDTH-1:0] rd_data_p1;
    logic [NREAD-1:0]       rd_vld_p1;

    // A write to the hardwired zero entry is accepted but must not land or bypass.
    assign wr_fire    = bus.wr_valid && wr_ready_q;
    assign wr_keep    = wr_fire && !(ZERO_REG && (bus.wr_sel == '0));
    assign clr_active = (state == CLEAR);

    // Clear sequencer: ready/busy are registered so they depend only on state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        ptr        <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    // ptr wraps to zero naturally because NREGS is a power of 2;
                    // a clr_req seen here is ignored so the sweep never restarts.
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ptr        <= '0;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: the sweep and the write port never overlap because writes
    // are only accepted in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++) mem[k] <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (clr_active && (ptr == AW'(k)))
                    mem[k] <= '0;
                else if (wr_keep && (bus.wr_sel == AW'(k)))
                    mem[k] <= bus.wr_data;
            end
        end
    end

    // Read value selection with write-first and clear-first bypass.
    always_comb begin
        logic [AW-1:0] s;
        for (int i = 0; i < NREAD; i++) begin
            s = bus.rd_sel[i*AW +: AW];
            rd_next[i] = mem[s];
            if (wr_keep && (bus.wr_sel == s))
                rd_next[i] = bus.wr_data;
            if (clr_active && (ptr == s))
                rd_next[i] = '0;
            if (ZERO_REG && (s == '0))
                rd_next[i] = '0;
        end
    end

    // ---- stage p1: registered read ports; data holds when the port is idle ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                rd_vld_p1[i] <= bus.rd_en[i];
                if (bus.rd_en[i])
                    rd_data_p1[i*WIDTH +: WIDTH] <= rd_next[i];
            end
        end
    end

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = rd_vld_p1;
    assign bus.busy     = busy_q;
    assign bus.wr_ready = wr_ready_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes hand-computed read results
// into per-port queues, a negedge monitor pops and compares on rd_valid.
module tb_reg_file_mp;
    localparam int WIDTH = 32;
    localparam int NREGS = 8;
    localparam int NREAD = 2;

`ifdef REG_FILE_MP_ZERO_REG_EN
    localparam logic [31:0] ZEXP = 32'h0;
`else
    localparam logic [31:0] ZEXP = 32'h1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   nchk = 0;
    int   nfail = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    reg_file_mp_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) bus ();

    reg_file_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every valid read beat must match the oldest expectation of its port.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.rd_valid[0]) begin
                if (q0.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL port0 unexpected rd_valid: got data %08h expected no valid", bus.rd_data[31:0]);
                end else check("port0 rd_data", bus.rd_data[31:0], q0.pop_front());
            end
            if (bus.rd_valid[1]) begin
                if (q1.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL port1 unexpected rd_valid: got data %08h expected no valid", bus.rd_data[63:32]);
                end else check("port1 rd_data", bus.rd_data[63:32], q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic e0, input logic [2:0] s0, input logic [31:0] x0,
                       input logic e1, input logic [2:0] s1, input logic [31:0] x1);
        bus.rd_en  = {e1, e0};
        bus.rd_sel = {s1, s0};
        if (e0) q0.push_back(x0);
        if (e1) q1.push_back(x1);
        tick();
        bus.rd_en = '0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_sel   = sel;
        bus.wr_data  = data;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int k = 0; k < NREGS; k++)
            rd2(1'b1, 3'(k), 32'h0, 1'b1, 3'(NREGS - 1 - k), 32'h0);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_sel   = '0;
        bus.wr_data  = '0;
        bus.rd_en    = '0;
        bus.rd_sel   = '0;
        bus.clr_req  = 1'b0;

        // Reset state
        tick(); tick();
        check("reset busy", {31'b0, bus.busy}, 32'h0);
        check("reset wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        check("reset rd_valid", {30'b0, bus.rd_valid}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("post-reset wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        check("post-reset busy", {31'b0, bus.busy}, 32'h0);
        read_all_zero();

        // Write then read on both ports
        wr(3'd5, 32'hDEADBEEF);
        rd2(1'b1, 3'd5, 32'hDEADBEEF, 1'b1, 3'd5, 32'hDEADBEEF);

        // Write-first bypass, both ports on the same index
        wr(3'd3, 32'hA5A5A5A5);
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 3'd3;
        bus.wr_data  = 32'h12345678;
        rd2(1'b1, 3'd3, 32'h12345678, 1'b1, 3'd3, 32'h12345678);
        bus.wr_valid = 1'b0;
        rd2(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 32'h12345678);
        check("port0 idle rd_valid", {31'b0, bus.rd_valid[0]}, 32'h0);
        check("port0 hold rd_data", bus.rd_data[31:0], 32'h12345678);

        // Index 0 write with same-cycle read
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 3'd0;
        bus.wr_data  = 32'h1;
        check("idx0 wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        rd2(1'b1, 3'd0, ZEXP, 1'b0, 3'd0, 32'h0);
        bus.wr_valid = 1'b0;
        check("idx0 wr_ready after", {31'b0, bus.wr_ready}, 32'h1);
        rd2(1'b1, 3'd0, ZEXP, 1'b1, 3'd0, ZEXP);

        // Clear sweep with writes held and a re-pulsed clr_req
        for (int k = 0; k < NREGS; k++) wr(3'(k), 32'hFFFFFFFF);
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 3'd2;
        bus.wr_data  = 32'h11111111;
        bus.clr_req  = 1'b1;
        check("pre-clear wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        tick();
        bus.clr_req = 1'b0;
        bus.wr_sel  = 3'd7;
        bus.wr_data = 32'h22222222;
        for (int c = 0; c < NREGS; c++) begin
            logic [31:0] x1;
            x1 = (c == 1) ? 32'h11111111 : ((c == 7) ? 32'h0 : 32'hFFFFFFFF);
            check("sweep busy", {31'b0, bus.busy}, 32'h1);
            check("sweep wr_ready", {31'b0, bus.wr_ready}, 32'h0);
            if (c == 3) bus.clr_req = 1'b1;
            rd2(1'b1, 3'(c), 32'h0, 1'b1, 3'((c + 1) % NREGS), x1);
            bus.clr_req = 1'b0;
        end
        bus.wr_valid = 1'b0;
        check("post-sweep busy", {31'b0, bus.busy}, 32'h0);
        check("post-sweep wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        read_all_zero();

        // Reset in the middle of a sweep
        wr(3'd4, 32'hCAFEF00D);
        wr(3'd6, 32'h0BADF00D);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick(); tick(); tick();
        rd2(1'b1, 3'd6, 32'h0BADF00D, 1'b0, 3'd0, 32'h0);
        check("mid-sweep busy", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, bus.busy}, 32'h0);
        check("async reset wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        check("async reset rd_valid", {30'b0, bus.rd_valid}, 32'h0);
        check("async reset rd_data0", bus.rd_data[31:0], 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        read_all_zero();

        tick(); tick();
        check("port0 pending reads", 32'(q0.size()), 32'h0);
        check("port1 pending reads", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
